// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared sizes and FSM state type for the register-file write arbiter
package regfile_pkg;

  localparam int NUM_REGS = 64;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 64;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - requester, clear and register-file port bundle
interface regfile_write_arbiter_if #(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
);

  logic              req_a_valid;
  logic [ADDR_W-1:0] req_a_addr;
  logic [DATA_W-1:0] req_a_data;
  logic              req_a_ready;

  logic              req_b_valid;
  logic [ADDR_W-1:0] req_b_addr;
  logic [DATA_W-1:0] req_b_data;
  logic              req_b_ready;

  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;
  logic              err_oor;

  logic [ADDR_W-1:0] rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic              rf_reg_write;
  logic              rf_En;

  // Requester / controller side
  modport master (
    output req_a_valid, req_a_addr, req_a_data,
    input  req_a_ready,
    output req_b_valid, req_b_addr, req_b_data,
    input  req_b_ready,
    output clr_start,
    input  clr_busy, clr_done, err_oor,
    input  rf_write_reg, rf_write_data, rf_reg_write, rf_En
  );

  // Arbiter side
  modport slave (
    input  req_a_valid, req_a_addr, req_a_data,
    output req_a_ready,
    input  req_b_valid, req_b_addr, req_b_data,
    output req_b_ready,
    input  clr_start,
    output clr_busy, clr_done, err_oor,
    output rf_write_reg, rf_write_data, rf_reg_write, rf_En
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// rtl/regfile_write_arbiter_rr_arb2.sv - two-way round-robin grant with pointer
module rr_arb2 (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // 0 favours requester 0 (A), 1 favours requester 1 (B)
  logic favour_b_q;

  // A lone requester wins outright; contention is settled by the pointer
  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || !favour_b_q)) begin
      grant[0] = 1'b1;
    end else if (req[1]) begin
      grant[1] = 1'b1;
    end
  end

  // Hand priority to the other side after every accepted transfer
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      favour_b_q <= 1'b0;
    end else if (accept) begin
      favour_b_q <= grant[0];
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester register-file write arbiter with bulk clear
module regfile_write_arbiter #(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int DATA_W   = regfile_pkg::DATA_W
) (
  input logic                    Clk,
  input logic                    Rst_n,
  regfile_write_arbiter_if.slave bus
);
  import regfile_pkg::*;

  // Compared one bit wider so NUM_REGS == 2**ADDR_W does not wrap to zero
  localparam logic [ADDR_W:0]   NUM_REGS_X = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic              clr_last;
  logic              arb_en;
  logic [1:0]        req, grant;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_oor;

  logic [ADDR_W-1:0] rf_write_reg_q;
  logic [DATA_W-1:0] rf_write_data_q;
  logic              rf_reg_write_q;
  logic              clr_done_q;
  logic              err_oor_q;

  // Readies are combinational, so Rst_n gates them directly to force them low in reset
  assign arb_en   = Rst_n && (state_q == ARB) && !bus.clr_start;
  assign req      = {bus.req_b_valid, bus.req_a_valid} & {2{arb_en}};
  assign accept   = |grant;
  assign sel_addr = grant[1] ? bus.req_b_addr : bus.req_a_addr;
  assign sel_data = grant[1] ? bus.req_b_data : bus.req_a_data;
  assign sel_oor  = {1'b0, sel_addr} >= NUM_REGS_X;
  assign clr_last = (cnt_q == LAST_IDX);

  rr_arb2 u_rr_arb2 (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .req    (req),
    .accept (accept),
    .grant  (grant)
  );

  // Next state: clear request leaves ARB, last clear write returns to ARB
  always_comb begin
    state_d = state_q;
    if (state_q == ARB) begin
      if (bus.clr_start) state_d = CLEAR;
    end else begin
      if (clr_last) state_d = ARB;
    end
  end

  // State register and clear counter; counter rests at 0 outside CLEAR
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ARB;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == CLEAR && !clr_last) ? cnt_q + ADDR_W'(1) : '0;
    end
  end

  // Registered register-file port; address/data hold when nothing is written
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rf_write_reg_q  <= '0;
      rf_write_data_q <= '0;
      rf_reg_write_q  <= 1'b0;
      clr_done_q      <= 1'b0;
      err_oor_q       <= 1'b0;
    end else begin
      rf_reg_write_q <= 1'b0;
      clr_done_q     <= 1'b0;
      err_oor_q      <= 1'b0;
      if (state_q == CLEAR) begin
        rf_write_reg_q  <= cnt_q;
        rf_write_data_q <= '0;
        rf_reg_write_q  <= 1'b1;
        clr_done_q      <= clr_last;
      end else if (accept) begin
        if (sel_oor) begin
          err_oor_q <= 1'b1;
        end else begin
          rf_write_reg_q  <= sel_addr;
          rf_write_data_q <= sel_data;
          rf_reg_write_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.req_a_ready   = grant[0];
  assign bus.req_b_ready   = grant[1];
  assign bus.clr_busy      = (state_q == CLEAR);
  assign bus.clr_done      = clr_done_q;
  assign bus.err_oor       = err_oor_q;
  assign bus.rf_write_reg  = rf_write_reg_q;
  assign bus.rf_write_data = rf_write_data_q;
  assign bus.rf_reg_write  = rf_reg_write_q;
  assign bus.rf_En         = rf_reg_write_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic Clk = 1'b0;
  logic Rst_n;
  always #5 Clk = ~Clk;

  regfile_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_write_arbiter #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic set_in(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                        input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
                        input logic cs);
    bus.req_a_valid = av; bus.req_a_addr = aa; bus.req_a_data = ad;
    bus.req_b_valid = bv; bus.req_b_addr = ba; bus.req_b_data = bd;
    bus.clr_start   = cs;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rf_we"}, bus.rf_reg_write, 0);
    chk({tag, "_rf_en"}, bus.rf_En, 0);
    chk({tag, "_rf_reg"}, bus.rf_write_reg, 0);
    chk({tag, "_rf_data"}, bus.rf_write_data, 0);
    chk({tag, "_ready_a"}, bus.req_a_ready, 0);
    chk({tag, "_ready_b"}, bus.req_b_ready, 0);
    chk({tag, "_busy"}, bus.clr_busy, 0);
    chk({tag, "_done"}, bus.clr_done, 0);
    chk({tag, "_err"}, bus.err_oor, 0);
  endtask

  // Enters at posedge+1, leaves at posedge+1 with reset released
  task automatic do_reset();
    Rst_n = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1 Rst_n = 1'b1;
  endtask

  // Reference model: clear progress, round-robin preference and the rf port
  // expected for the current cycle (result of the previous cycle's decision)
  bit                m_clear;
  int                m_idx;
  bit                m_fav_b;
  logic              m_we, m_err, m_done;
  logic [ADDR_W-1:0] m_reg;
  logic [DATA_W-1:0] m_data;

  task automatic model_reset();
    m_clear = 0; m_idx = 0; m_fav_b = 0;
    m_we = 0; m_err = 0; m_done = 0; m_reg = '0; m_data = '0;
  endtask

  task automatic model_cycle(output bit ra, output bit rb);
    bit av, bv;
    av = bus.req_a_valid;
    bv = bus.req_b_valid;
    if (m_clear || bus.clr_start) begin
      ra = 0; rb = 0;
    end else if (av && bv) begin
      ra = !m_fav_b; rb = m_fav_b;
    end else begin
      ra = av; rb = bv;
    end
    chk("rnd_ready_a", bus.req_a_ready, ra);
    chk("rnd_ready_b", bus.req_b_ready, rb);
    chk("rnd_rf_we", bus.rf_reg_write, m_we);
    chk("rnd_rf_en", bus.rf_En, m_we);
    chk("rnd_rf_reg", bus.rf_write_reg, m_reg);
    chk("rnd_rf_data", bus.rf_write_data, m_data);
    chk("rnd_err", bus.err_oor, m_err);
    chk("rnd_done", bus.clr_done, m_done);
    chk("rnd_busy", bus.clr_busy, m_clear);
    m_we = 0; m_err = 0; m_done = 0;
    if (m_clear) begin
      m_we = 1; m_reg = ADDR_W'(m_idx); m_data = '0;
      if (m_idx == NUM_REGS - 1) begin
        m_done = 1; m_clear = 0; m_idx = 0;
      end else begin
        m_idx++;
      end
    end else if (bus.clr_start) begin
      m_clear = 1; m_idx = 0;
    end else if (ra || rb) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      a = ra ? bus.req_a_addr : bus.req_b_addr;
      d = ra ? bus.req_a_data : bus.req_b_data;
      m_fav_b = ra;
      if (int'(a) >= NUM_REGS) m_err = 1;
      else begin m_we = 1; m_reg = a; m_data = d; end
    end
  endtask

  typedef struct {
    logic              av;
    logic [ADDR_W-1:0] aa;
    logic [DATA_W-1:0] ad;
    logic              bv;
    logic [ADDR_W-1:0] ba;
    logic [DATA_W-1:0] bd;
    logic              ra, rb, we;
    logic [ADDR_W-1:0] wreg;
    logic [DATA_W-1:0] wdata;
    logic              err;
  } vec_t;

  function automatic vec_t mk(logic av, int aa, logic [63:0] ad, logic bv, int ba, logic [63:0] bd,
                              logic ra, logic rb, logic we, int wreg, logic [63:0] wdata, logic err);
    vec_t v;
    v.av = av; v.aa = ADDR_W'(aa); v.ad = ad;
    v.bv = bv; v.ba = ADDR_W'(ba); v.bd = bd;
    v.ra = ra; v.rb = rb; v.we = we; v.wreg = ADDR_W'(wreg); v.wdata = wdata; v.err = err;
    return v;
  endfunction

  vec_t vecs[11];

  initial begin
    bit found, seen_done;
    int wr_idx, done_cnt;
    logic              pa_v, pb_v;
    logic [ADDR_W-1:0] pa_a, pb_a;
    logic [DATA_W-1:0] pa_d, pb_d;
    bit ra, rb;

    // inputs; ready A/B; rf port seen this cycle (from last cycle); err
    vecs[0]  = mk(1, 5,  64'hDEAD, 0, 0,  0,     1, 0, 0, 0,  0,        0);
    vecs[1]  = mk(0, 0,  0,        0, 0,  0,     0, 0, 1, 5,  64'hDEAD, 0);
    vecs[2]  = mk(0, 0,  0,        1, 7,  64'h77, 0, 1, 0, 5,  64'hDEAD, 0);
    vecs[3]  = mk(1, 10, 64'hA0,   1, 20, 64'hB0, 1, 0, 1, 7,  64'h77,   0);
    vecs[4]  = mk(1, 11, 64'hA1,   1, 20, 64'hB0, 0, 1, 1, 10, 64'hA0,   0);
    vecs[5]  = mk(1, 11, 64'hA1,   1, 21, 64'hB1, 1, 0, 1, 20, 64'hB0,   0);
    vecs[6]  = mk(1, 12, 64'hA2,   1, 21, 64'hB1, 0, 1, 1, 11, 64'hA1,   0);
    vecs[7]  = mk(0, 0,  0,        0, 0,  0,     0, 0, 1, 21, 64'hB1,   0);
    vecs[8]  = mk(0, 0,  0,        1, 64, 64'h64, 0, 1, 0, 21, 64'hB1,   0);
    vecs[9]  = mk(0, 0,  0,        0, 0,  0,     0, 0, 0, 21, 64'hB1,   1);
    vecs[10] = mk(0, 0,  0,        0, 0,  0,     0, 0, 0, 21, 64'hB1,   0);

    Rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    #2 chk_all_zero("reset");
    @(posedge Clk);
    @(posedge Clk);
    #1 Rst_n = 1'b1;

    // Directed vectors: single write, alternating grants, out-of-range drop
    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd, 0);
      #4;
      chk($sformatf("vec%0d_ready_a", i), bus.req_a_ready, vecs[i].ra);
      chk($sformatf("vec%0d_ready_b", i), bus.req_b_ready, vecs[i].rb);
      chk($sformatf("vec%0d_rf_we", i), bus.rf_reg_write, vecs[i].we);
      chk($sformatf("vec%0d_rf_en", i), bus.rf_En, vecs[i].we);
      chk($sformatf("vec%0d_rf_reg", i), bus.rf_write_reg, vecs[i].wreg);
      chk($sformatf("vec%0d_rf_data", i), bus.rf_write_data, vecs[i].wdata);
      chk($sformatf("vec%0d_err", i), bus.err_oor, vecs[i].err);
      @(posedge Clk);
      #1;
    end

    // Clear with a simultaneous A request; A must wait until the clr_done cycle
    set_in(1, 3, 64'h33, 0, 0, 0, 1);
    #4 chk("clr_start_ready_a", bus.req_a_ready, 0);
    @(posedge Clk);
    #1 bus.clr_start = 0;
    seen_done = 0; wr_idx = 0; done_cnt = 0;
    for (int i = 0; i < 100 && !seen_done; i++) begin
      #4;
      if (bus.rf_reg_write) begin
        chk("clr_addr", bus.rf_write_reg, ADDR_W'(wr_idx));
        chk("clr_data", bus.rf_write_data, 0);
        wr_idx++;
      end
      if (bus.clr_done) begin
        seen_done = 1; done_cnt++;
        chk("clr_done_ready_a", bus.req_a_ready, 1);
        chk("clr_done_busy", bus.clr_busy, 0);
      end else begin
        chk("clr_ready_a", bus.req_a_ready, 0);
        chk("clr_busy", bus.clr_busy, 1);
      end
      @(posedge Clk);
      #1;
    end
    chk("clr_done_seen", seen_done, 1);
    chk("clr_write_count", wr_idx, NUM_REGS);
    bus.req_a_valid = 0;
    #4;
    chk("post_clr_done_pulse", bus.clr_done, 0);
    chk("post_clr_rf_we", bus.rf_reg_write, 1);
    chk("post_clr_rf_reg", bus.rf_write_reg, 3);
    chk("post_clr_rf_data", bus.rf_write_data, 64'h33);
    @(posedge Clk);
    #1;

    // Reset in the middle of a clear (internal counter at 20)
    set_in(0, 0, 0, 0, 0, 0, 1);
    @(posedge Clk);
    #1 set_in(1, 9, 64'h99, 1, 10, 64'h1010, 0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      #4;
      if (bus.rf_reg_write && bus.rf_write_reg == ADDR_W'(19)) found = 1;
      else begin @(posedge Clk); #1; end
    end
    chk("midclr_reached", found, 1);
    Rst_n = 1'b0;
    #1 chk_all_zero("midclr_reset");
    @(posedge Clk);
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    #4;
    chk("rst_rel_ready_a", bus.req_a_ready, 1);
    chk("rst_rel_ready_b", bus.req_b_ready, 0);
    chk("rst_rel_busy", bus.clr_busy, 0);
    chk("rst_rel_rf_we", bus.rf_reg_write, 0);
    @(posedge Clk);
    #1 bus.req_a_valid = 0;
    #4;
    chk("rst_rel_b_ready", bus.req_b_ready, 1);
    chk("rst_rel_rf_reg_a", bus.rf_write_reg, 9);
    chk("rst_rel_rf_data_a", bus.rf_write_data, 64'h99);
    @(posedge Clk);
    #1 bus.req_b_valid = 0;
    #4;
    chk("rst_rel_rf_reg_b", bus.rf_write_reg, 10);
    @(posedge Clk);
    #5;
    chk("rst_rel_no_clear_we", bus.rf_reg_write, 0);
    chk("rst_rel_no_clear_busy", bus.clr_busy, 0);
    @(posedge Clk);
    #1;

    // Randomized traffic against the reference model
    set_in(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    model_reset();
    pa_v = 0; pb_v = 0; pa_a = '0; pb_a = '0; pa_d = '0; pb_d = '0;
    ra = 0; rb = 0;
    for (int i = 0; i < 800; i++) begin
      if (!pa_v || ra) begin
        pa_v = ($urandom_range(0, 2) != 0);
        pa_a = ADDR_W'($urandom_range(0, NUM_REGS + 6));
        pa_d = {$urandom, $urandom};
      end
      if (!pb_v || rb) begin
        pb_v = ($urandom_range(0, 2) != 0);
        pb_a = ADDR_W'($urandom_range(0, NUM_REGS + 6));
        pb_d = {$urandom, $urandom};
      end
      set_in(pa_v, pa_a, pa_d, pb_v, pb_a, pb_d, ($urandom_range(0, 59) == 0));
      #4 model_cycle(ra, rb);
      @(posedge Clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
